// File: rtl/imm_rot_encoder_pkg.sv
// Shared types and constants for the rotated-immediate encoder.
package imm_rot_encoder_pkg;

  localparam int ROT_STEPS = 16;
  localparam int IMM8_W    = 8;
  localparam int ROT_W     = 4;
  localparam int SHOP_W    = 12;
  localparam int VALUE_W   = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    NEG_SEARCH = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/imm_rot_encoder_if.sv
// Request/result bundle between a requester (master) and the encoder (slave).
interface imm_rot_encoder_if;
  import imm_rot_encoder_pkg::*;

  logic                start;
  logic [VALUE_W-1:0]  value;
  logic                ready;
  logic                busy;
  logic                done;
  logic                ok;
  logic                inv;
  logic [SHOP_W-1:0]   shifter_operand;

  modport master (
    output start, value,
    input  ready, busy, done, ok, inv, shifter_operand
  );

  modport slave (
    input  start, value,
    output ready, busy, done, ok, inv, shifter_operand
  );
endinterface

// File: rtl/imm_rot_encoder_rot_candidate_check.sv
// Tests one rotation candidate: rotating the value left by 2*r must leave
// only the low byte populated; that byte is then the imm8 field.
module rot_candidate_check
  import imm_rot_encoder_pkg::*;
(
  input  logic [VALUE_W-1:0] value,
  input  logic [ROT_W-1:0]   r,
  output logic               hit,
  output logic [IMM8_W-1:0]  imm8
);

  logic [5:0]         sh;
  logic [VALUE_W-1:0] rol;

  // Rotate left by 2r; a right shift by 32 yields 0, so r=0 is the identity.
  always_comb begin
    sh   = {1'b0, r, 1'b0};
    rol  = (value << sh) | (value >> (6'd32 - sh));
    hit  = ~|rol[VALUE_W-1:IMM8_W];
    imm8 = rol[IMM8_W-1:0];
  end

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative search for the ARM rotated-immediate encoding of a 32-bit value.
// Optional build macro IMM_ENC_NEG_EN adds a second pass over ~value (MVN form).
module imm_rot_encoder
  import imm_rot_encoder_pkg::*;
#(
  parameter int CANDS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  imm_rot_encoder_if.slave bus
);

  localparam logic [ROT_W-1:0] LAST_CNT = ROT_W'(ROT_STEPS - CANDS_PER_CYCLE);
  // Only used when another group follows, so CANDS_PER_CYCLE=16 never needs it.
  localparam logic [ROT_W-1:0] CNT_STEP = ROT_W'(CANDS_PER_CYCLE % ROT_STEPS);

  state_t              state;
  logic [ROT_W-1:0]    rot_cnt;
  logic [VALUE_W-1:0]  lat_value;
  logic [VALUE_W-1:0]  cand_value;
  logic                ready_q, busy_q, done_q, ok_q;
  logic [SHOP_W-1:0]   shop_q;

  logic [CANDS_PER_CYCLE-1:0] hit_v;
  logic [IMM8_W-1:0]          imm_v [CANDS_PER_CYCLE];
  logic [ROT_W-1:0]           r_v   [CANDS_PER_CYCLE];
  logic                       any_hit;
  logic [ROT_W-1:0]           win_r;
  logic [IMM8_W-1:0]          win_imm;

`ifdef IMM_ENC_NEG_EN
  logic inv_q;
  assign cand_value = (state == NEG_SEARCH) ? ~lat_value : lat_value;
`else
  assign cand_value = lat_value;
`endif

  for (genvar gi = 0; gi < CANDS_PER_CYCLE; gi++) begin : g_cand
    assign r_v[gi] = rot_cnt + ROT_W'(gi);
    rot_candidate_check u_check (
      .value (cand_value),
      .r     (r_v[gi]),
      .hit   (hit_v[gi]),
      .imm8  (imm_v[gi])
    );
  end

  // Priority select: scanning high to low lets the smallest hitting r win.
  always_comb begin
    any_hit = 1'b0;
    win_r   = '0;
    win_imm = '0;
    for (int i = CANDS_PER_CYCLE - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        any_hit = 1'b1;
        win_r   = r_v[i];
        win_imm = imm_v[i];
      end
    end
  end

  // Operand capture on an accepted request; later changes on value are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start)
      lat_value <= bus.value;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rot_cnt <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      shop_q  <= '0;
`ifdef IMM_ENC_NEG_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SEARCH;
            rot_cnt <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            ok_q    <= 1'b0;
            shop_q  <= '0;
`ifdef IMM_ENC_NEG_EN
            inv_q   <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (any_hit) begin
            ok_q   <= 1'b1;
            shop_q <= {win_r, win_imm};
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (rot_cnt == LAST_CNT) begin
            ok_q   <= 1'b0;
            shop_q <= '0;
`ifdef IMM_ENC_NEG_EN
            state   <= NEG_SEARCH;
            rot_cnt <= '0;
`else
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end else begin
            rot_cnt <= rot_cnt + CNT_STEP;
          end
        end
`ifdef IMM_ENC_NEG_EN
        NEG_SEARCH: begin
          if (any_hit) begin
            ok_q   <= 1'b1;
            inv_q  <= 1'b1;
            shop_q <= {win_r, win_imm};
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (rot_cnt == LAST_CNT) begin
            ok_q   <= 1'b0;
            inv_q  <= 1'b0;
            shop_q <= '0;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            rot_cnt <= rot_cnt + CNT_STEP;
          end
        end
`endif
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready           = ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.ok              = ok_q;
  assign bus.shifter_operand = shop_q;
`ifdef IMM_ENC_NEG_EN
  assign bus.inv             = inv_q;
`else
  assign bus.inv             = 1'b0;
`endif

endmodule
